// File: rtl/mouse_pkg.sv
// Shared types and default constants for the mouse-repel scheduler and the
// particle physics blocks.
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EVAL,
    WRITE,
    NEXT,
    DONE
  } state_t;

  localparam int          DEF_FRAC   = 12;
  localparam int          DEF_RADIUS = 20;
  localparam logic [31:0] DEF_PUSH   = 32'h0000_A000;

endpackage

// File: rtl/mouse_proximity_eval.sv
// Combinational mouse proximity test and push computation for one particle.
// Define MOUSE_REPEL_Y_EN to push y as well as x.
module mouse_proximity_eval
  import mouse_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               FRAC   = DEF_FRAC,
  parameter int               RADIUS = DEF_RADIUS,
  parameter logic [WIDTH-1:0] PUSH   = WIDTH'(DEF_PUSH)
) (
  input  logic [WIDTH-1:0] mx,
  input  logic [WIDTH-1:0] my,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  output logic             close,
  output logic [WIDTH-1:0] new_x,
  output logic [WIDTH-1:0] new_y
);

  localparam logic [WIDTH-1:0] RAD = WIDTH'(RADIUS);

  logic [WIDTH-1:0] dx, dy, adx, ady;

  assign dx  = mx - px;
  assign dy  = my - py;
  // The most-negative difference negates to itself, so it can never be close.
  assign adx = dx[WIDTH-1] ? -dx : dx;
  assign ady = dy[WIDTH-1] ? -dy : dy;

  assign close = ((adx >> FRAC) < RAD) && ((ady >> FRAC) < RAD);
  assign new_x = dx[WIDTH-1] ? (px + PUSH) : (px - PUSH);

`ifdef MOUSE_REPEL_Y_EN
  assign new_y = dy[WIDTH-1] ? (py + PUSH) : (py - PUSH);
`else
  assign new_y = py;
`endif

endmodule

// File: rtl/mouse_repel_scheduler.sv
// Walks the particle position RAM once per start, pushing particles near the
// latched mouse position. MOUSE_REPEL_Y_EN enables the y push as well.
module mouse_repel_scheduler
  import mouse_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               FRAC   = DEF_FRAC,
  parameter int               N_PART = 64,
  parameter int               ADDR_W = 6,
  parameter int               RADIUS = DEF_RADIUS,
  parameter logic [WIDTH-1:0] PUSH   = WIDTH'(DEF_PUSH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  mouse_x,
  input  logic [WIDTH-1:0]  mouse_y,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rd_x,
  input  logic [WIDTH-1:0]  mem_rd_y,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_wr_x,
  output logic [WIDTH-1:0]  mem_wr_y,
  output logic [ADDR_W:0]   hit_cnt
);

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N_PART - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   HIT_ONE  = (ADDR_W + 1)'(1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] idx;
  logic [WIDTH-1:0]  mx, my, px, py;
  logic [WIDTH-1:0]  new_x_r, new_y_r;
  logic [ADDR_W:0]   hit_acc;

  logic              ev_close;
  logic [WIDTH-1:0]  ev_x, ev_y;

  mouse_proximity_eval #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .RADIUS(RADIUS),
    .PUSH  (PUSH)
  ) u_eval (
    .mx   (mx),
    .my   (my),
    .px   (px),
    .py   (py),
    .close(ev_close),
    .new_x(ev_x),
    .new_y(ev_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    nxt       = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wr_x  = '0;
    mem_wr_y  = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = READ;
      end
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = idx;
        nxt       = WAIT;
      end
      WAIT: nxt = EVAL;
      EVAL: nxt = ev_close ? WRITE : NEXT;
      WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = idx;
        mem_wr_x  = new_x_r;
        mem_wr_y  = new_y_r;
        nxt       = NEXT;
      end
      NEXT: nxt = (idx == LAST) ? DONE : READ;
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      mx      <= '0;
      my      <= '0;
      px      <= '0;
      py      <= '0;
      new_x_r <= '0;
      new_y_r <= '0;
      hit_acc <= '0;
      hit_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          mx      <= mouse_x;
          my      <= mouse_y;
          idx     <= '0;
          hit_acc <= '0;
        end
        WAIT: begin
          px <= mem_rd_x;
          py <= mem_rd_y;
        end
        EVAL: begin
          new_x_r <= ev_x;
          new_y_r <= ev_y;
          if (ev_close) hit_acc <= hit_acc + HIT_ONE;
        end
        // Publish the count as DONE is entered so it is valid alongside done.
        NEXT: begin
          if (idx == LAST) hit_cnt <= hit_acc;
          else             idx     <= idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_repel_scheduler.sv
// Scoreboard bench for mouse_repel_scheduler with a 4-entry particle RAM model.
module tb_mouse_repel_scheduler;

  localparam int NP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   mouse_x = '0, mouse_y = '0;
  logic          busy, done, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rd_x, mem_rd_y, mem_wr_x, mem_wr_y;
  logic [AW:0]   hit_cnt;

  mouse_repel_scheduler #(
    .WIDTH(32), .FRAC(12), .N_PART(NP), .ADDR_W(AW), .RADIUS(20), .PUSH(32'h0000A000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y), .mem_wr_en(mem_wr_en),
    .mem_wr_x(mem_wr_x), .mem_wr_y(mem_wr_y), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, plus a bench-side load port.
  logic [31:0]   mem_x [NP];
  logic [31:0]   mem_y [NP];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [31:0]   ld_x = '0, ld_y = '0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_x <= mem_x[mem_addr];
      mem_rd_y <= mem_y[mem_addr];
    end
    if (mem_wr_en) begin
      mem_x[mem_addr] <= mem_wr_x;
      mem_y[mem_addr] <= mem_wr_y;
    end
    if (ld_en) begin
      mem_x[ld_a] <= ld_x;
      mem_y[ld_a] <= ld_y;
    end
  end

  typedef struct { int addr; logic [31:0] x; logic [31:0] y; } wr_t;
  typedef struct { int hit; int cyc; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ysel(input logic [31:0] x_only, input logic [31:0] y_en);
`ifdef MOUSE_REPEL_Y_EN
    return y_en;
`else
    return x_only;
`endif
  endfunction

  task automatic exp_wr(input int a, input logic [31:0] x, input logic [31:0] y);
    wr_t e;
    e.addr = a; e.x = x; e.y = y;
    wr_q.push_back(e);
  endtask

  task automatic exp_done(input int hit, input int cyc);
    dn_t e;
    e.hit = hit; e.cyc = cyc;
    dn_q.push_back(e);
  endtask

  task automatic load(input int a, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    ld_en = 1'b1; ld_a = AW'(a); ld_x = x; ld_y = y;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  int busy_cyc = 0;
  initial begin
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cyc = 0;
      end else begin
        if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", 32'd1, 32'd0);
        if (busy) busy_cyc++;
        if (mem_wr_en) begin
          if (wr_q.size() == 0) chk("unexpected_write", {30'd0, mem_addr}, 32'hFFFF_FFFF);
          else begin
            w = wr_q.pop_front();
            chk("wr_addr", {30'd0, mem_addr}, w.addr);
            chk("wr_x", mem_wr_x, w.x);
            chk("wr_y", mem_wr_y, w.y);
          end
        end
        if (done) begin
          if (dn_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            d = dn_q.pop_front();
            chk("hit_cnt", {29'd0, hit_cnt}, d.hit);
            chk("sweep_cycles", busy_cyc, d.cyc);
          end
          busy_cyc = 0;
        end
      end
    end
  end

  // Mouse inputs are scrambled right after accept; the latched values must hold.
  task automatic run_sweep(input logic [31:0] mx, input logic [31:0] my, input bit hold);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    mouse_x = mx; mouse_y = my; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    mouse_x = 32'h0; mouse_y = 32'h0;
    for (int n = 0; n < 300; n++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_sweep", {31'd0, busy}, 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("dn_q_drained", dn_q.size(), 32'd0);
    wr_q.delete();
    dn_q.delete();
  endtask

  initial begin
    bit hit2;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_addr", {30'd0, mem_addr}, 32'd0);
    chk("rst_wr_x", mem_wr_x, 32'd0);
    chk("rst_wr_y", mem_wr_y, 32'd0);
    chk("rst_hit_cnt", {29'd0, hit_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All particles right/above of mouse by 5.0: each pushed away by +10.0.
    for (int i = 0; i < NP; i++) load(i, 32'h5000, 32'h5000);
    for (int i = 0; i < NP; i++) exp_wr(i, 32'h0000F000, ysel(32'h5000, 32'h0000F000));
    exp_done(4, 21);
    run_sweep(32'h0, 32'h0, 1'b0);

    // Radius edge: exactly 20 is out, 19.99 is in; dx==0 / dy==0 push negative.
    load(0, 32'h00014000, 32'h0);
    load(1, 32'h00013FFF, 32'h0);
    load(2, 32'h0,        32'h00014000);
    load(3, 32'hFFFFF000, 32'h0);
    exp_wr(1, 32'h0001DFFF, ysel(32'h0, 32'hFFFF6000));
    exp_wr(3, 32'hFFFF5000, ysel(32'h0, 32'hFFFF6000));
    exp_done(2, 19);
    run_sweep(32'h0, 32'h0, 1'b0);

    // Particle right of mouse moves right; far particles untouched.
    load(0, 32'h3000, 32'h3000);
    for (int i = 1; i < NP; i++) load(i, 32'h00100000, 32'h00100000);
    exp_wr(0, 32'h0000D000, ysel(32'h3000, 32'h0000D000));
    exp_done(1, 18);
    run_sweep(32'h1000, 32'h1000, 1'b0);

    // Most-negative dx never close; start held across the whole sweep.
    for (int i = 0; i < NP; i++) load(i, 32'h0, 32'h0);
    exp_done(0, 17);
    run_sweep(32'h80000000, 32'h0, 1'b1);

    // Reset during the write of index 2.
    for (int i = 0; i < NP; i++) load(i, 32'h5000, 32'h5000);
    for (int i = 0; i < 3; i++) exp_wr(i, 32'h0000F000, ysel(32'h5000, 32'h0000F000));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit2 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (mem_wr_en && mem_addr == 2'd2) begin hit2 = 1'b1; break; end
      @(negedge clk);
    end
    chk("write2_seen", {31'd0, hit2}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hit_cnt", {29'd0, hit_cnt}, 32'd0);
    chk("arst_wr_q", wr_q.size(), 32'd0);
    wr_q.delete();
    @(negedge clk);
    chk("mem_x0_kept", mem_x[0], 32'h0000F000);
    chk("mem_x1_kept", mem_x[1], 32'h0000F000);
    chk("mem_x2_unwritten", mem_x[2], 32'h5000);
    rst_n = 1'b1;

    // Fresh sweep must start at index 0: entries 0,1 now 15.0 away.
    exp_wr(0, 32'h00019000, ysel(32'h5000, 32'h00019000));
    exp_wr(1, 32'h00019000, ysel(32'h5000, 32'h00019000));
    exp_wr(2, 32'h0000F000, ysel(32'h5000, 32'h0000F000));
    exp_wr(3, 32'h0000F000, ysel(32'h5000, 32'h0000F000));
    exp_done(4, 21);
    run_sweep(32'h0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
